s1_resposta_jogador: RTL and testbench
======================================

// Module: s1_resposta_jogador
// PURPOSE
//   Player-side responder to the S1 control FSM. Conditions raw buttons into one
//   jogada pulse per press with a latched code, runs timer T (timeout) and
//   timer T2 (muda_leds pacing). Obeys zeraT/contaT/zeraT2/contaT2 and habilita.
// PARAMETERS
//   NBOTOES   4     number of buttons / width of jogada code
//   DEBOUNCE  16    cycles a synchronized vector must hold before it is accepted
//   T_JOGADA  5000  timer T terminal count; cycles of contaT before timeout
//   T_LEDS    1000  timer T2 period; cycles of contaT2 per muda_leds pulse
// PORTS
//   clock           in   1        system clock, all logic on rising edge
//   reset           in   1        asynchronous, active-low reset
//   botoes          in   NBOTOES  raw asynchronous buttons, 1 = pressed
//   habilita        in   1        FSM accepts presses (driven by mostraB)
//   zeraT           in   1        clear timer T
//   contaT          in   1        advance timer T
//   zeraT2          in   1        clear timer T2
//   contaT2         in   1        advance timer T2
//   jogada          out  1        one-cycle pulse: accepted press
//   jogada_codigo   out  NBOTOES  debounced vector of last accepted press
//   jogada_invalida out  1        last accepted press had >1 button set
//   timeout         out  1        level: timer T reached T_JOGADA-1
//   muda_leds       out  1        one-cycle pulse: T2 period elapsed
//   db_botoes       out  NBOTOES  debounced button vector (debug)
//   db_estado       out  2        press FSM state (debug)
// BEHAVIOUR
//   Reset (reset=0): all registers, counters and outputs 0; FSM to OCIOSO.
//   Input path: 2-flop synchronizer on botoes. Debounce on the whole vector:
//     candidate != synced -> candidate<=synced, cnt<=0; else cnt increments;
//     when cnt==DEBOUNCE-1, estavel<=candidate (cnt saturates). db_botoes=estavel.
//   Press FSM (db_estado): OCIOSO=0, PRESSIONADO=1, BLOQUEADO=2.
//     OCIOSO: estavel!=0 & habilita  -> PRESSIONADO; same edge latch
//             jogada_codigo<=estavel, jogada_invalida<=(popcount>1), jogada<=1.
//             estavel!=0 & !habilita -> BLOQUEADO (no pulse).
//     PRESSIONADO / BLOQUEADO: estavel==0 -> OCIOSO; else stay.
//   jogada is registered, high exactly one cycle per press; code/invalida held
//     until next accepted press. habilita falling mid-press: no effect; a
//     button already held when habilita rises is ignored until released.
//   Latency raw stable press -> jogada high: 2 + DEBOUNCE + 1 cycles.
//   Timer T (width clog2(T_JOGADA)): zeraT has priority -> 0; else contaT and
//     cnt<T_JOGADA-1 -> +1; saturates at T_JOGADA-1. timeout=(cnt==T_JOGADA-1),
//     registered-state decode, cleared only by zeraT or reset.
//   Timer T2 (width clog2(T_LEDS)): zeraT2 priority -> 0; else contaT2 -> +1,
//     wraps T_LEDS-1 -> 0. muda_leds=contaT2 & !zeraT2 & (cnt2==T_LEDS-1),
//     so one pulse per T_LEDS counted cycles; contaT2 low freezes count.
//   Simultaneous zera and conta: zera wins. Reset mid-press or mid-count: all
//     state cleared immediately; no spurious jogada/muda_leds after release.
// TESTING  (DEBOUNCE=4, T_JOGADA=20, T_LEDS=8, NBOTOES=4)
//   Reset: hold reset=0 with botoes=4'b0010 -> all outputs 0, db_estado=0.
//   Press: habilita=1, botoes=4'b0100 held 20 cycles -> one jogada pulse 7
//     cycles after edge, jogada_codigo=4'b0100, invalida=0; no 2nd pulse.
//   Bounce/multi: toggle bit0 every 2 cycles, then hold 4'b0011 -> single pulse,
//     code=4'b0011, invalida=1; held-before-habilita press -> no pulse.
//   Timeout: zeraT 1 cycle, contaT=1 for 19 cycles -> timeout rises on cycle 19,
//     stays high with contaT; zeraT with contaT -> timeout 0 next cycle.
//   muda_leds: contaT2=1 for 24 cycles -> pulses on cycles 8,16,24; zeraT2 at
//     cycle 5 then count -> next pulse 8 cycles later.
//   Reset mid-op: assert reset during PRESSIONADO and T2=6 -> all cleared; after
//     release no pulse until a new full press / 8 new contaT2 cycles.

Source files
------------

// File: rtl/s1_resposta_jogador_if.sv
// s1_resposta_jogador_if
//   Bundle between the S1 control FSM (master) and the player-side responder
//   (slave).
//   master drives: botoes, habilita, zeraT, contaT, zeraT2, contaT2
//   slave drives : jogada, jogada_codigo, jogada_invalida, timeout, muda_leds,
//                  db_botoes, db_estado
interface s1_resposta_jogador_if #(
    parameter int NBOTOES = 4
);
    logic [NBOTOES-1:0] botoes;
    logic               habilita;
    logic               zeraT;
    logic               contaT;
    logic               zeraT2;
    logic               contaT2;
    logic               jogada;
    logic [NBOTOES-1:0] jogada_codigo;
    logic               jogada_invalida;
    logic               timeout;
    logic               muda_leds;
    logic [NBOTOES-1:0] db_botoes;
    logic [1:0]         db_estado;

    modport master (
        output botoes, habilita, zeraT, contaT, zeraT2, contaT2,
        input  jogada, jogada_codigo, jogada_invalida, timeout, muda_leds,
               db_botoes, db_estado
    );

    modport slave (
        input  botoes, habilita, zeraT, contaT, zeraT2, contaT2,
        output jogada, jogada_codigo, jogada_invalida, timeout, muda_leds,
               db_botoes, db_estado
    );
endinterface

// File: rtl/s1_resposta_jogador.sv
// s1_resposta_jogador
//   Player-side responder to the S1 control FSM. Synchronizes and debounces the
//   raw buttons, emits one jogada pulse per accepted press with a latched code,
//   and runs timer T (timeout) and timer T2 (muda_leds pacing).
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : slave side of s1_resposta_jogador_if (buttons, habilita, timer
//           controls in; jogada/code/invalida, timeout, muda_leds, debug out)
module s1_resposta_jogador #(
    parameter int NBOTOES  = 4,
    parameter int DEBOUNCE = 16,
    parameter int T_JOGADA = 5000,
    parameter int T_LEDS   = 1000
) (
    input logic                    clock,
    input logic                    reset,
    s1_resposta_jogador_if.slave   bus
);
    localparam int WD  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int WT  = (T_JOGADA > 1) ? $clog2(T_JOGADA) : 1;
    localparam int WT2 = (T_LEDS   > 1) ? $clog2(T_LEDS)   : 1;

    localparam logic [WD-1:0]      DB_MAX = WD'(DEBOUNCE - 1);
    localparam logic [WT-1:0]      T_MAX  = WT'(T_JOGADA - 1);
    localparam logic [WT2-1:0]     T2_MAX = WT2'(T_LEDS - 1);
    localparam logic [NBOTOES-1:0] UM     = NBOTOES'(1);

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        PRESSIONADO = 2'd1,
        BLOQUEADO   = 2'd2
    } estado_t;

    logic [NBOTOES-1:0] r_sync1, r_sync2, r_cand, r_estavel;
    logic [WD-1:0]      r_db_cnt;
    estado_t            r_estado;
    logic               r_jogada;
    logic [NBOTOES-1:0] r_codigo;
    logic               r_invalida;
    logic [WT-1:0]      r_cnt_t;
    logic [WT2-1:0]     r_cnt_t2;
    logic               w_multi;

    // Synchronizer + whole-vector debounce. estavel is loaded on the edge the
    // counter reaches DEBOUNCE-1, so a vector held for DEBOUNCE synced cycles
    // is accepted; afterwards the counter saturates and estavel keeps tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_cand    <= '0;
            r_db_cnt  <= '0;
            r_estavel <= '0;
        end else begin
            r_sync1 <= bus.botoes;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand   <= r_sync2;
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_MAX) begin
                r_estavel <= r_cand;
            end else begin
                r_db_cnt <= r_db_cnt + WD'(1);
                if (r_db_cnt == DB_MAX - WD'(1))
                    r_estavel <= r_cand;
            end
        end
    end

    // More than one bit set: clearing the lowest set bit leaves something.
    assign w_multi = (r_estavel & (r_estavel - UM)) != '0;

    // Press FSM with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= OCIOSO;
            r_jogada   <= 1'b0;
            r_codigo   <= '0;
            r_invalida <= 1'b0;
        end else begin
            r_jogada <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (r_estavel != '0) begin
                        if (bus.habilita) begin
                            r_estado   <= PRESSIONADO;
                            r_jogada   <= 1'b1;
                            r_codigo   <= r_estavel;
                            r_invalida <= w_multi;
                        end else begin
                            r_estado <= BLOQUEADO;
                        end
                    end
                end
                PRESSIONADO, BLOQUEADO: begin
                    if (r_estavel == '0)
                        r_estado <= OCIOSO;
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    // Timer T saturates at T_JOGADA-1; timer T2 wraps every T_LEDS counts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt_t  <= '0;
            r_cnt_t2 <= '0;
        end else begin
            if (bus.zeraT)
                r_cnt_t <= '0;
            else if (bus.contaT && r_cnt_t != T_MAX)
                r_cnt_t <= r_cnt_t + WT'(1);

            if (bus.zeraT2)
                r_cnt_t2 <= '0;
            else if (bus.contaT2)
                r_cnt_t2 <= (r_cnt_t2 == T2_MAX) ? '0 : r_cnt_t2 + WT2'(1);
        end
    end

    assign bus.jogada          = r_jogada;
    assign bus.jogada_codigo   = r_codigo;
    assign bus.jogada_invalida = r_invalida;
    assign bus.timeout         = (r_cnt_t == T_MAX);
    assign bus.muda_leds       = bus.contaT2 && !bus.zeraT2 && (r_cnt_t2 == T2_MAX);
    assign bus.db_botoes       = r_estavel;
    assign bus.db_estado       = r_estado;
endmodule

// File: tb/tb_s1_resposta_jogador.sv
// tb_s1_resposta_jogador
//   Directed bench for s1_resposta_jogador with DEBOUNCE=4, T_JOGADA=20,
//   T_LEDS=8, NBOTOES=4. Inputs change on the falling edge; outputs are
//   sampled on the falling edge (or #1 after it for combinational muda_leds).
module tb_s1_resposta_jogador;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   pulses;

    s1_resposta_jogador_if #(.NBOTOES(4)) bus ();

    s1_resposta_jogador #(
        .NBOTOES (4),
        .DEBOUNCE(4),
        .T_JOGADA(20),
        .T_LEDS  (8)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance n cycles, counting jogada pulses seen at each falling edge.
    task automatic run_count(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.jogada === 1'b1) pulses++;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        pulses = 0;
        rst_n        = 1'b0;
        bus.botoes   = 4'b0010;
        bus.habilita = 1'b0;
        bus.zeraT    = 1'b0;
        bus.contaT   = 1'b0;
        bus.zeraT2   = 1'b0;
        bus.contaT2  = 1'b0;

        // Reset with a button held
        repeat (4) tick();
        check_eq("rst_jogada",   bus.jogada,          0);
        check_eq("rst_codigo",   bus.jogada_codigo,   0);
        check_eq("rst_invalida", bus.jogada_invalida, 0);
        check_eq("rst_timeout",  bus.timeout,         0);
        check_eq("rst_muda",     bus.muda_leds,       0);
        check_eq("rst_db_bot",   bus.db_botoes,       0);
        check_eq("rst_estado",   bus.db_estado,       0);
        bus.botoes = 4'b0000;
        rst_n = 1'b1;
        repeat (8) tick();

        // Single clean press: pulse exactly on cycle 7
        bus.habilita = 1'b1;
        bus.botoes   = 4'b0100;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check_eq($sformatf("press_jogada_c%0d", i), bus.jogada, (i == 7) ? 1 : 0);
        end
        check_eq("press_codigo",   bus.jogada_codigo,   4'b0100);
        check_eq("press_invalida", bus.jogada_invalida, 0);
        check_eq("press_db_bot",   bus.db_botoes,       4'b0100);
        check_eq("press_estado",   bus.db_estado,       1);
        bus.botoes = 4'b0000;
        pulses = 0;
        run_count(10);
        check_eq("release_pulses", pulses, 0);
        check_eq("release_estado", bus.db_estado, 0);

        // Bouncing bit0 then a held two-button press
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            bus.botoes = ((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000;
            run_count(1);
        end
        check_eq("bounce_pulses", pulses, 0);
        bus.botoes = 4'b0011;
        run_count(15);
        check_eq("multi_pulses",   pulses, 1);
        check_eq("multi_codigo",   bus.jogada_codigo,   4'b0011);
        check_eq("multi_invalida", bus.jogada_invalida, 1);
        bus.botoes = 4'b0000;
        run_count(10);

        // Press held before habilita rises is ignored until released
        pulses = 0;
        bus.habilita = 1'b0;
        bus.botoes   = 4'b1000;
        run_count(10);
        check_eq("blk_estado", bus.db_estado, 2);
        bus.habilita = 1'b1;
        run_count(10);
        check_eq("blk_pulses",  pulses, 0);
        check_eq("blk_estado2", bus.db_estado, 2);
        check_eq("blk_codigo",  bus.jogada_codigo, 4'b0011);
        bus.botoes = 4'b0000;
        run_count(10);
        check_eq("blk_release", bus.db_estado, 0);

        // Timer T
        bus.zeraT = 1'b1;
        tick();
        bus.zeraT  = 1'b0;
        bus.contaT = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            check_eq($sformatf("timeout_c%0d", k), bus.timeout, (k == 19) ? 1 : 0);
        end
        repeat (3) tick();
        check_eq("timeout_hold", bus.timeout, 1);
        bus.zeraT = 1'b1;
        tick();
        check_eq("timeout_zera", bus.timeout, 0);
        bus.zeraT  = 1'b0;
        bus.contaT = 1'b0;

        // Timer T2: pulses on counted cycles 8, 16, 24
        bus.zeraT2 = 1'b1;
        tick();
        bus.zeraT2  = 1'b0;
        bus.contaT2 = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            #1;
            check_eq($sformatf("muda_c%0d", c), bus.muda_leds, (c % 8 == 0) ? 1 : 0);
            tick();
        end
        // zeraT2 on cycle 5 restarts the period: next pulse on cycle 13
        for (int c = 1; c <= 13; c++) begin
            bus.zeraT2 = (c == 5);
            #1;
            check_eq($sformatf("muda_z_c%0d", c), bus.muda_leds, (c == 13) ? 1 : 0);
            tick();
        end
        bus.zeraT2  = 1'b0;
        bus.contaT2 = 1'b0;

        // Reset mid-press and mid-count
        bus.zeraT2 = 1'b1;
        tick();
        bus.zeraT2  = 1'b0;
        bus.contaT2 = 1'b1;
        repeat (6) tick();
        bus.contaT2 = 1'b0;
        bus.botoes  = 4'b0001;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) check_eq("mid_jogada", bus.jogada, 1);
        end
        check_eq("mid_estado", bus.db_estado, 1);
        rst_n      = 1'b0;
        bus.botoes = 4'b0000;
        #1;
        check_eq("mid_rst_estado", bus.db_estado,     0);
        check_eq("mid_rst_codigo", bus.jogada_codigo, 0);
        check_eq("mid_rst_db_bot", bus.db_botoes,     0);
        tick();
        tick();
        rst_n = 1'b1;
        bus.contaT2 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            #1;
            check_eq($sformatf("post_muda_c%0d", c), bus.muda_leds, (c == 8) ? 1 : 0);
            check_eq($sformatf("post_jogada_c%0d", c), bus.jogada, 0);
            tick();
        end
        bus.contaT2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
